// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the L1 miss sequencer: FSM states, field widths and
// the RAM address layout used for both write-back and fill.
package cache_ctrl_pkg;

    localparam int unsigned IDX_W  = 2;
    localparam int unsigned TAG_W  = 3;
    localparam int unsigned DAT_W  = 3;
    localparam int unsigned ADDR_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWriteback,
        StFillWait,
        StAlloc,
        StFill,
        StResp
    } state_e;

    // A line is one word, so its RAM address is simply {0, tag, index}.
    function automatic logic [ADDR_W-1:0] ram_addr(input logic [TAG_W-1:0] tag,
                                                   input logic [IDX_W-1:0] idx);
        return {{(ADDR_W - TAG_W - IDX_W){1'b0}}, tag, idx};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_miss_ctrl.sv
// One-request-at-a-time sequencer between the CPU port, a 2-way 4-set L1 array and RAM:
// tag lookup, hit completion, dirty write-back, RAM fill / store allocate, LRU update.
module cache_miss_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned RAM_RD_LAT = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    input  logic             we,
    input  logic [7:0]       addr,
    input  logic [2:0]       wdata,
    output logic             ready,
    output logic             done,
    output logic [2:0]       rdata,
    output logic [1:0]       cache_index,
    output logic [2:0]       cache_tag,
    input  logic             hit,
    input  logic             hit_way,
    input  logic [2:0]       hit_data,
    input  logic             victim_way,
    input  logic             victim_valid,
    input  logic             victim_dirty,
    input  logic [2:0]       victim_tag,
    input  logic [2:0]       victim_data,
    output logic             cache_wr,
    output logic             cache_way,
    output logic [2:0]       cache_wtag,
    output logic [2:0]       cache_wdata,
    output logic             cache_wdirty,
    output logic             lru_touch,
    output logic [7:0]       ram_address,
    output logic [7:0]       data_ram,
    output logic             wren_ram,
    input  logic [7:0]       qram,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    localparam int unsigned LatW = (RAM_RD_LAT > 1) ? $clog2(RAM_RD_LAT) : 1;
    localparam logic [LatW-1:0] LatInit = LatW'(RAM_RD_LAT - 1);

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [DAT_W-1:0]   wdata_q, wdata_d;
    logic               vway_q, vway_d;
    logic [TAG_W-1:0]   vtag_q, vtag_d;
    logic [DAT_W-1:0]   vdata_q, vdata_d;
    logic [DAT_W-1:0]   rdata_q, rdata_d;
    logic [LatW-1:0]    lat_q, lat_d;
    logic               hit_inc, miss_inc, wb_inc;

    // Upper address bits and upper RAM data bits carry nothing for this cache.
    logic unused_bits;
    assign unused_bits = ^{qram[7:DAT_W], addr[7:5]};

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        idx_d        = idx_q;
        tag_d        = tag_q;
        wdata_d      = wdata_q;
        vway_d       = vway_q;
        vtag_d       = vtag_q;
        vdata_d      = vdata_q;
        rdata_d      = rdata_q;
        lat_d        = lat_q;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        wb_inc       = 1'b0;
        ready        = 1'b0;
        done         = 1'b0;
        cache_wr     = 1'b0;
        cache_way    = 1'b0;
        cache_wtag   = '0;
        cache_wdata  = '0;
        cache_wdirty = 1'b0;
        lru_touch    = 1'b0;
        ram_address  = '0;
        data_ram     = '0;
        wren_ram     = 1'b0;
        cache_index  = (state_q != StIdle) ? idx_q : '0;
        cache_tag    = (state_q != StIdle) ? tag_q : '0;

        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (req) begin
                    we_d    = we;
                    idx_d   = addr[1:0];
                    tag_d   = addr[4:2];
                    wdata_d = wdata;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (hit) begin
                    hit_inc   = 1'b1;
                    lru_touch = 1'b1;
                    cache_way = hit_way;
                    if (we_q) begin
                        cache_wr     = 1'b1;
                        cache_wtag   = tag_q;
                        cache_wdata  = wdata_q;
                        cache_wdirty = 1'b1;
                    end else begin
                        rdata_d = hit_data;
                    end
                    state_d = StResp;
                end else begin
                    miss_inc = 1'b1;
                    vway_d   = victim_way;
                    vtag_d   = victim_tag;
                    vdata_d  = victim_data;
                    if (victim_valid && victim_dirty) begin
                        state_d = StWriteback;
                    end else if (we_q) begin
                        state_d = StAlloc;
                    end else begin
                        state_d = StFillWait;
                        lat_d   = LatInit;
                    end
                end
            end
            StWriteback: begin
                wren_ram    = 1'b1;
                ram_address = ram_addr(vtag_q, idx_q);
                data_ram    = {{(ADDR_W - DAT_W){1'b0}}, vdata_q};
                wb_inc      = 1'b1;
                if (we_q) begin
                    state_d = StAlloc;
                end else begin
                    state_d = StFillWait;
                    lat_d   = LatInit;
                end
            end
            StFillWait: begin
                ram_address = ram_addr(tag_q, idx_q);
                if (lat_q == '0) begin
                    state_d = StFill;
                end else begin
                    lat_d = lat_q - LatW'(1);
                end
            end
            StFill: begin
                cache_wr    = 1'b1;
                cache_way   = vway_q;
                cache_wtag  = tag_q;
                cache_wdata = qram[DAT_W-1:0];
                lru_touch   = 1'b1;
                rdata_d     = qram[DAT_W-1:0];
                state_d     = StResp;
            end
            StAlloc: begin
                cache_wr     = 1'b1;
                cache_way    = vway_q;
                cache_wtag   = tag_q;
                cache_wdata  = wdata_q;
                cache_wdirty = 1'b1;
                lru_touch    = 1'b1;
                state_d      = StResp;
            end
            StResp: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            idx_q   <= '0;
            tag_q   <= '0;
            wdata_q <= '0;
            vway_q  <= 1'b0;
            vtag_q  <= '0;
            vdata_q <= '0;
            rdata_q <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
            wdata_q <= wdata_d;
            vway_q  <= vway_d;
            vtag_q  <= vtag_d;
            vdata_q <= vdata_d;
            rdata_q <= rdata_d;
            lat_q   <= lat_d;
        end
    end

    assign rdata = rdata_q;

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (miss_inc),
        .count (miss_count)
    );

    sat_counter #(.W(CNT_W)) u_wb_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (wb_inc),
        .count (wb_count)
    );

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl: a queue of expected completions is checked by a
// monitor on every done pulse, alongside cycle-accurate strobe and counter checks.
module tb_cache_miss_ctrl;

    localparam int unsigned LAT = 2;
    localparam int unsigned CW  = 8;

    logic          clock, reset;
    logic          req, we;
    logic [7:0]    addr;
    logic [2:0]    wdata;
    logic          ready, done;
    logic [2:0]    rdata;
    logic [1:0]    cache_index;
    logic [2:0]    cache_tag;
    logic          hit, hit_way;
    logic [2:0]    hit_data;
    logic          victim_way, victim_valid, victim_dirty;
    logic [2:0]    victim_tag, victim_data;
    logic          cache_wr, cache_way, cache_wdirty, lru_touch;
    logic [2:0]    cache_wtag, cache_wdata;
    logic [7:0]    ram_address, data_ram, qram;
    logic          wren_ram;
    logic [CW-1:0] hit_count, miss_count, wb_count;

    cache_miss_ctrl #(.RAM_RD_LAT(LAT), .CNT_W(CW)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .ready        (ready),
        .done         (done),
        .rdata        (rdata),
        .cache_index  (cache_index),
        .cache_tag    (cache_tag),
        .hit          (hit),
        .hit_way      (hit_way),
        .hit_data     (hit_data),
        .victim_way   (victim_way),
        .victim_valid (victim_valid),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .victim_data  (victim_data),
        .cache_wr     (cache_wr),
        .cache_way    (cache_way),
        .cache_wtag   (cache_wtag),
        .cache_wdata  (cache_wdata),
        .cache_wdirty (cache_wdirty),
        .lru_touch    (lru_touch),
        .ram_address  (ram_address),
        .data_ram     (data_ram),
        .wren_ram     (wren_ram),
        .qram         (qram),
        .hit_count    (hit_count),
        .miss_count   (miss_count),
        .wb_count     (wb_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // RAM read model: data for an address appears LAT cycles after it is presented.
    logic [7:0] pipe [LAT];
    always @(posedge clock) begin
        pipe[0] <= ram_address;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign qram = (pipe[LAT-1] == 8'h0E) ? 8'hFD : 8'h00;

    typedef struct {
        logic       is_load;
        logic [2:0] rdata;
        int         lat;
        int         t0;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   done_seen = 0;

    function automatic void chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (!reset && done) begin
            done_seen++;
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending request");
            end else begin
                e = sbq.pop_front();
                chk("latency", cyc - e.t0, e.lat);
                if (e.is_load) chk("rdata", int'(rdata), int'(e.rdata));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 30) begin
            tick();
            n++;
        end
        if (!ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 30 cycles");
        end
    endtask

    task automatic set_array(input logic h, input logic hw, input logic [2:0] hd,
                             input logic vw, input logic vv, input logic vdty,
                             input logic [2:0] vt, input logic [2:0] vdat);
        hit = h; hit_way = hw; hit_data = hd;
        victim_way = vw; victim_valid = vv; victim_dirty = vdty;
        victim_tag = vt; victim_data = vdat;
    endtask

    // Presents one request; returns in the lookup cycle.
    task automatic issue(input logic w, input logic [7:0] a, input logic [2:0] d,
                         input logic [2:0] exp_r, input int lat);
        exp_t e;
        wait_ready();
        we = w; addr = a; wdata = d; req = 1'b1;
        e.is_load = !w; e.rdata = exp_r; e.lat = lat; e.t0 = cyc;
        sbq.push_back(e);
        tick();
        req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int d0;
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        set_array(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_cache_wr", cache_wr, 0);
        chk("rst_ram_address", ram_address, 0);
        chk("rst_hit_count", hit_count, 0);
        reset = 1'b0;
        tick();

        // Load hit
        set_array(1, 1, 3'b110, 0, 0, 0, 0, 0);
        issue(0, 8'h05, 0, 3'b110, 2);
        chk("lh_ready", ready, 0);
        chk("lh_lru_touch", lru_touch, 1);
        chk("lh_cache_way", cache_way, 1);
        chk("lh_cache_wr", cache_wr, 0);
        chk("lh_index", cache_index, 1);
        chk("lh_tag", cache_tag, 1);
        tick();
        tick();
        chk("lh_hit_count", hit_count, 1);
        chk("lh_ready_back", ready, 1);

        // Clean load miss with a stray request and address change after acceptance
        set_array(0, 0, 0, 0, 1, 0, 3'b010, 3'b111);
        issue(0, 8'h0E, 0, 3'b101, 5);
        addr = 8'hFF; req = 1'b1;
        chk("lm_index", cache_index, 2);
        chk("lm_tag", cache_tag, 3);
        chk("lm_lru_touch", lru_touch, 0);
        for (int i = 0; i < LAT; i++) begin
            tick();
            chk("lm_fw_ram_address", ram_address, 8'h0E);
            chk("lm_fw_wren", wren_ram, 0);
            chk("lm_fw_cache_wr", cache_wr, 0);
        end
        tick();
        req = 1'b0;
        chk("lm_fill_wr", cache_wr, 1);
        chk("lm_fill_wdata", cache_wdata, 3'b101);
        chk("lm_fill_wdirty", cache_wdirty, 0);
        chk("lm_fill_way", cache_way, 0);
        chk("lm_fill_wtag", cache_wtag, 3);
        chk("lm_fill_lru", lru_touch, 1);
        tick();
        tick();
        chk("lm_done_count", done_seen, 2);
        chk("lm_miss_count", miss_count, 1);
        chk("lm_wb_count", wb_count, 0);

        // Store miss with a dirty victim
        set_array(0, 0, 0, 1, 1, 1, 3'b101, 3'b010);
        issue(1, 8'h07, 3'b011, 0, 4);
        wdata = 3'b000;
        chk("sm_lookup_wr", cache_wr, 0);
        tick();
        chk("sm_wb_wren", wren_ram, 1);
        chk("sm_wb_address", ram_address, 8'h17);
        chk("sm_wb_data", data_ram, 8'h02);
        tick();
        chk("sm_alloc_wr", cache_wr, 1);
        chk("sm_alloc_way", cache_way, 1);
        chk("sm_alloc_wdirty", cache_wdirty, 1);
        chk("sm_alloc_wdata", cache_wdata, 3'b011);
        chk("sm_alloc_wtag", cache_wtag, 1);
        chk("sm_alloc_lru", lru_touch, 1);
        chk("sm_alloc_wren", wren_ram, 0);
        chk("sm_alloc_ram_address", ram_address, 0);
        tick();
        tick();
        chk("sm_wb_count", wb_count, 1);
        chk("sm_miss_count", miss_count, 2);

        // Store hit
        set_array(1, 0, 3'b001, 0, 0, 0, 0, 0);
        issue(1, 8'h1C, 3'b100, 0, 2);
        chk("sh_wr", cache_wr, 1);
        chk("sh_wdirty", cache_wdirty, 1);
        chk("sh_wdata", cache_wdata, 3'b100);
        chk("sh_wtag", cache_wtag, 7);
        chk("sh_way", cache_way, 0);
        tick();
        tick();
        chk("sh_hit_count", hit_count, 2);

        // Reset while waiting on RAM aborts the request
        set_array(0, 0, 0, 0, 1, 0, 3'b010, 3'b111);
        issue(0, 8'h0E, 0, 3'b101, 5);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sbq.delete();
        chk("ra_ready", ready, 1);
        chk("ra_cache_wr", cache_wr, 0);
        chk("ra_lru_touch", lru_touch, 0);
        chk("ra_wren", wren_ram, 0);
        chk("ra_hit_count", hit_count, 0);
        chk("ra_miss_count", miss_count, 0);
        chk("ra_wb_count", wb_count, 0);
        d0 = done_seen;
        for (int i = 0; i < 6; i++) tick();
        chk("ra_no_done", done_seen, d0);

        // Hit counter saturation
        set_array(1, 0, 3'b011, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) issue(0, 8'(i), 0, 3'b011, 2);
        tick();
        tick();
        chk("sat_hit_count", hit_count, 255);
        chk("sat_miss_count", miss_count, 0);

        for (int i = 0; i < 3; i++) tick();
        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
